// File: rtl/cic_pkg.sv
// Shared constants and elaboration-time helpers for the variable-rate CIC decimator.
package cic_pkg;

    localparam int MIN_RATE = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Smallest accumulator that cannot lose information for the widest rate word.
    function automatic int acc_width(input int in_w, input int stages, input int rate_w);
        return in_w + stages * rate_w;
    endfunction

    function automatic longint sat_max(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int out_w);
        return -(64'sd1 <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One pipelined comb stage: on an arriving token, outputs x - x_prev and forwards the token.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int WIDTH = 96
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] comb_q;
    logic [WIDTH-1:0] delay_q;
    logic             valid_q;

    // Flush drops any in-flight token along with the stored history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comb_q  <= '0;
            delay_q <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            comb_q  <= '0;
            delay_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                comb_q  <= data_i - delay_q;
                delay_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = comb_q;

endmodule

// File: rtl/cic_decim_var.sv
// Variable-rate CIC decimator for one real stream: qualified integrators, rate counter,
// pipelined combs, round-half-up output shift and saturation with a clip flag.
module cic_decim_var
    import cic_pkg::*;
#(
    parameter int STAGES       = 5,
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 24,
    parameter int RATE_WIDTH   = 16,
    parameter int ACC_WIDTH    = 96,
    parameter int SHIFT_WIDTH  = 7,
    parameter int DEFAULT_RATE = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic [RATE_WIDTH-1:0]  rate,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   out_valid,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   clip
);

    localparam int AW1 = ACC_WIDTH + 1;
    localparam logic [31:0] MAX_SHIFT = 32'(ACC_WIDTH - OUT_WIDTH);
    localparam logic signed [ACC_WIDTH:0] SAT_HI    = AW1'(sat_max(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SAT_LO    = AW1'(sat_min(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH:0] ROUND_ONE = AW1'(1);

    if (ACC_WIDTH < acc_width(IN_WIDTH, STAGES, RATE_WIDTH)) begin : g_bad_acc
        $error("cic_decim_var: ACC_WIDTH is smaller than IN_WIDTH + STAGES*RATE_WIDTH");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("cic_decim_var: STAGES must be in 1..8");
    end

    logic [ACC_WIDTH-1:0]   inExt;
    logic [ACC_WIDTH-1:0]   integ_q [STAGES];
    logic [RATE_WIDTH-1:0]  rate_q;
    logic [RATE_WIDTH-1:0]  rate_d;
    logic [RATE_WIDTH-1:0]  cnt_q;
    logic [RATE_WIDTH-1:0]  cnt_d;
    logic                   lastSample;
    logic [ACC_WIDTH-1:0]   c0_q;
    logic                   c0Valid_q;
    logic [SHIFT_WIDTH-1:0] shiftPipe_q [STAGES+1];
    logic [STAGES:0]        combValid;
    logic [ACC_WIDTH-1:0]   combData [STAGES+1];

    logic [31:0]                shiftAmt;
    logic signed [ACC_WIDTH:0]  combExt;
    logic signed [ACC_WIDTH:0]  roundAdd;
    logic signed [ACC_WIDTH:0]  roundSum;
    logic signed [ACC_WIDTH:0]  scaled_d;
    logic signed [ACC_WIDTH:0]  scaled_q;
    logic                       scaleValid_q;
    logic                       outValid_q;
    logic [OUT_WIDTH-1:0]       outData_q;
    logic                       clip_q;

    assign inExt = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    // Each integrator adds the previous stage's pre-edge value, so the chain is one sample per stage deep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
            end
        end else if (in_valid) begin
            integ_q[0] <= integ_q[0] + inExt;
            for (int k = 1; k < STAGES; k++) begin
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
        end
    end

    always_comb begin
        rate_d     = (rate < RATE_WIDTH'(MIN_RATE)) ? RATE_WIDTH'(MIN_RATE) : rate;
        lastSample = in_valid && (cnt_q == rate_q - RATE_WIDTH'(1));
        cnt_d      = cnt_q;
        if (in_valid) begin
            cnt_d = lastSample ? '0 : cnt_q + RATE_WIDTH'(1);
        end
    end

    // The shift is captured with each decimated sample and travels beside its comb token.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q    <= RATE_WIDTH'(DEFAULT_RATE);
            cnt_q     <= '0;
            c0_q      <= '0;
            c0Valid_q <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                shiftPipe_q[k] <= '0;
            end
        end else if (flush) begin
            rate_q    <= rate_d;
            cnt_q     <= '0;
            c0_q      <= '0;
            c0Valid_q <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                shiftPipe_q[k] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            c0Valid_q <= lastSample;
            if (lastSample) begin
                c0_q           <= integ_q[STAGES-1];
                shiftPipe_q[0] <= shift;
            end
            for (int k = 1; k <= STAGES; k++) begin
                shiftPipe_q[k] <= shiftPipe_q[k-1];
            end
        end
    end

    assign combValid[0] = c0Valid_q;
    assign combData[0]  = c0_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        cic_comb_stage #(
            .WIDTH (ACC_WIDTH)
        ) u_comb (
            .clk     (clk),
            .reset   (reset),
            .flush_i (flush),
            .valid_i (combValid[k]),
            .data_i  (combData[k]),
            .valid_o (combValid[k+1]),
            .data_o  (combData[k+1])
        );
    end

    // One guard bit keeps the rounding add from wrapping before the arithmetic shift.
    always_comb begin
        shiftAmt = 32'(shiftPipe_q[STAGES]);
        if (shiftAmt > MAX_SHIFT) begin
            shiftAmt = MAX_SHIFT;
        end
        combExt  = {combData[STAGES][ACC_WIDTH-1], combData[STAGES]};
        roundAdd = '0;
        if (shiftAmt != 32'd0) begin
            roundAdd = ROUND_ONE << (shiftAmt - 32'd1);
        end
        roundSum = combExt + roundAdd;
        scaled_d = roundSum >>> shiftAmt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scaled_q     <= '0;
            scaleValid_q <= 1'b0;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            clip_q       <= 1'b0;
        end else if (flush) begin
            scaled_q     <= '0;
            scaleValid_q <= 1'b0;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            clip_q       <= 1'b0;
        end else begin
            scaleValid_q <= combValid[STAGES];
            if (combValid[STAGES]) begin
                scaled_q <= scaled_d;
            end
            outValid_q <= scaleValid_q;
            if (scaleValid_q) begin
                if (scaled_q > SAT_HI) begin
                    outData_q <= SAT_HI[OUT_WIDTH-1:0];
                    clip_q    <= 1'b1;
                end else if (scaled_q < SAT_LO) begin
                    outData_q <= SAT_LO[OUT_WIDTH-1:0];
                    clip_q    <= 1'b1;
                end else begin
                    outData_q <= scaled_q[OUT_WIDTH-1:0];
                    clip_q    <= 1'b0;
                end
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_cic_decim_var.sv
// Bench for cic_decim_var: constant-input vector table, flush/reset/gap/rate sequences and
// random traffic checked against an impulse-response model of the decimator.
module tb_cic_decim_var;

    localparam int STAGES       = 5;
    localparam int IN_WIDTH     = 16;
    localparam int OUT_WIDTH    = 24;
    localparam int RATE_WIDTH   = 16;
    localparam int ACC_WIDTH    = 96;
    localparam int SHIFT_WIDTH  = 7;
    localparam int DEFAULT_RATE = 4;
    localparam int LATENCY      = STAGES + 2;
    localparam longint OUT_MAX  = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
    localparam longint OUT_MIN  = -(64'sd1 <<< (OUT_WIDTH - 1));

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic [IN_WIDTH-1:0]    in_data;
    logic [RATE_WIDTH-1:0]  rate;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   out_valid;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   clip;

    typedef struct {
        longint value;
        bit     clipped;
        int     due;
    } expect_t;

    typedef struct {
        int     rate;
        int     shift;
        longint data;
        longint expOut;
        bit     expClip;
    } vec_t;

    longint  hist[$];
    longint  taps[$];
    expect_t pending[$];
    int      pulseCycles[$];
    int      acceptCycles[$];
    int      modelRate;
    longint  lastOut;
    bit      lastClip;
    int      cycle;
    int      passCount;
    int      checkCount;
    vec_t    vecs[6];

    cic_decim_var #(
        .STAGES       (STAGES),
        .IN_WIDTH     (IN_WIDTH),
        .OUT_WIDTH    (OUT_WIDTH),
        .RATE_WIDTH   (RATE_WIDTH),
        .ACC_WIDTH    (ACC_WIDTH),
        .SHIFT_WIDTH  (SHIFT_WIDTH),
        .DEFAULT_RATE (DEFAULT_RATE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .rate      (rate),
        .shift     (shift),
        .out_valid (out_valid),
        .out_data  (out_data),
        .clip      (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Impulse response of R-sample box filter cascaded STAGES times.
    function automatic void buildTaps(input int r);
        longint tmp[$];
        longint acc;
        taps = {};
        taps.push_back(64'sd1);
        for (int st = 0; st < STAGES; st++) begin
            tmp = {};
            for (int i = 0; i < taps.size() + r - 1; i++) begin
                acc = 0;
                for (int j = 0; j < r; j++) begin
                    if (i - j >= 0 && i - j < taps.size()) begin
                        acc += taps[i-j];
                    end
                end
                tmp.push_back(acc);
            end
            taps = tmp;
        end
    endfunction

    // Decimated output: filtered input delayed by one sample per integrator, then scaled.
    function automatic expect_t modelCapture(input int due);
        expect_t e;
        longint  y;
        logic signed [127:0] t;
        int      s;
        int      n;
        int      idx;
        n = hist.size();
        y = 0;
        for (int j = 0; j < taps.size(); j++) begin
            idx = n - STAGES - j;
            if (idx >= 1) begin
                y += taps[j] * hist[idx-1];
            end
        end
        s = int'(shift);
        if (s > ACC_WIDTH - OUT_WIDTH) begin
            s = ACC_WIDTH - OUT_WIDTH;
        end
        t = 128'(y);
        if (s > 0) begin
            t = t + (128'sd1 <<< (s - 1));
        end
        t = t >>> s;
        if (t > 128'(OUT_MAX)) begin
            e.value   = OUT_MAX;
            e.clipped = 1'b1;
        end else if (t < 128'(OUT_MIN)) begin
            e.value   = OUT_MIN;
            e.clipped = 1'b1;
        end else begin
            e.value   = 64'(t);
            e.clipped = 1'b0;
        end
        e.due = due;
        return e;
    endfunction

    task automatic modelStep();
        if (flush) begin
            hist.delete();
            pending.delete();
            modelRate = (rate < 2) ? 2 : int'(rate);
            buildTaps(modelRate);
            lastOut  = 0;
            lastClip = 1'b0;
        end else if (in_valid) begin
            hist.push_back(longint'($signed(in_data)));
            acceptCycles.push_back(cycle + 1);
            if (hist.size() % modelRate == 0) begin
                pending.push_back(modelCapture(cycle + 1 + LATENCY));
            end
        end
    endtask

    task automatic checkOutput();
        bit expValid;
        expValid = (pending.size() > 0) && (pending[0].due == cycle);
        check("out_valid", longint'(out_valid), longint'(expValid));
        if (expValid) begin
            lastOut  = pending[0].value;
            lastClip = pending[0].clipped;
            void'(pending.pop_front());
        end
        if (out_valid) begin
            pulseCycles.push_back(cycle);
        end
        check("out_data", longint'($signed(out_data)), lastOut);
        check("clip", longint'(clip), longint'(lastClip));
    endtask

    task automatic applyStimulus(input bit v, input longint d, input bit f);
        in_valid = v;
        in_data  = IN_WIDTH'(d);
        flush    = f;
        modelStep();
        @(posedge clk);
        cycle++;
        #1;
        checkOutput();
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 0, 1'b0);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        hist.delete();
        pending.delete();
        modelRate = DEFAULT_RATE;
        buildTaps(modelRate);
        lastOut  = 0;
        lastClip = 1'b0;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_data", longint'($signed(out_data)), 0);
        check("reset_clip", longint'(clip), 0);
        #2;
        reset = 1'b0;
    endtask

    task automatic checkPeriod(input string name, input int period);
        for (int k = 1; k < pulseCycles.size(); k++) begin
            check(name, longint'(pulseCycles[k] - pulseCycles[k-1]), longint'(period));
        end
    endtask

    function automatic longint rnd(input int span);
        return longint'($urandom_range(0, 2 * span)) - longint'(span);
    endfunction

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        reset      = 1'b0;
        rate       = RATE_WIDTH'(DEFAULT_RATE);
        shift      = '0;
        cycle      = 0;
        passCount  = 0;
        checkCount = 0;
        lastOut    = 0;
        lastClip   = 1'b0;
        modelRate  = DEFAULT_RATE;
        doReset();

        vecs[0] = '{4,  0,  1,      1024,     1'b0};
        vecs[1] = '{4,  10, 1,      1,        1'b0};
        vecs[2] = '{2,  6,  3,      2,        1'b0};
        vecs[3] = '{2,  6,  -3,     -1,       1'b0};
        vecs[4] = '{16, 0,  32767,  8388607,  1'b1};
        vecs[5] = '{16, 0,  -32768, -8388608, 1'b1};
        for (int i = 0; i < 6; i++) begin
            rate  = RATE_WIDTH'(vecs[i].rate);
            shift = SHIFT_WIDTH'(vecs[i].shift);
            applyStimulus(1'b0, 0, 1'b1);
            for (int n = 0; n < (STAGES + 3) * vecs[i].rate; n++) begin
                applyStimulus(1'b1, vecs[i].data, 1'b0);
            end
            idle(LATENCY + 2);
            check($sformatf("vec%0d_out_data", i), longint'($signed(out_data)), vecs[i].expOut);
            check($sformatf("vec%0d_clip", i), longint'(clip), longint'(vecs[i].expClip));
        end

        // Gapped input: one accepted sample every third cycle.
        rate  = 16'd4;
        shift = 7'd0;
        applyStimulus(1'b0, 0, 1'b1);
        pulseCycles.delete();
        acceptCycles.delete();
        for (int i = 0; i < 72; i++) begin
            applyStimulus(i % 3 == 0, rnd(1000), 1'b0);
        end
        idle(LATENCY + 2);
        check("gap_pulses", longint'(pulseCycles.size()), 6);
        if (pulseCycles.size() > 0 && acceptCycles.size() > 3) begin
            check("gap_latency", longint'(pulseCycles[0] - acceptCycles[3]), longint'(LATENCY));
        end
        checkPeriod("gap_period", 12);

        // Rate change without flush is ignored.
        rate = 16'd4;
        applyStimulus(1'b0, 0, 1'b1);
        rate = 16'd8;
        pulseCycles.delete();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, rnd(3000), 1'b0);
        end
        idle(LATENCY + 2);
        check("norate_pulses", longint'(pulseCycles.size()), 10);
        checkPeriod("norate_period", 4);

        // Flush right after a token is launched kills it.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, rnd(3000), 1'b0);
        end
        pulseCycles.delete();
        applyStimulus(1'b1, rnd(3000), 1'b1);
        idle(LATENCY + 3);
        check("flush_kill", longint'(pulseCycles.size()), 0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, rnd(3000), 1'b0);
        end
        idle(LATENCY + 2);
        check("rate8_pulses", longint'(pulseCycles.size()), 4);
        checkPeriod("rate8_period", 8);

        rate = 16'd0;
        applyStimulus(1'b0, 0, 1'b1);
        pulseCycles.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, rnd(3000), 1'b0);
        end
        idle(LATENCY + 2);
        check("rate0_pulses", longint'(pulseCycles.size()), 5);
        checkPeriod("rate0_period", 2);

        // Reset while a token sits in the comb pipe; rate returns to the default.
        rate  = 16'd3;
        shift = 7'd2;
        applyStimulus(1'b0, 0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 500, 1'b0);
        end
        idle(2);
        doReset();
        pulseCycles.delete();
        acceptCycles.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 500, 1'b0);
        end
        idle(LATENCY + 2);
        check("rst_pulses", longint'(pulseCycles.size()), 1);
        if (pulseCycles.size() > 0 && acceptCycles.size() > 3) begin
            check("rst_latency", longint'(pulseCycles[0] - acceptCycles[3]), longint'(LATENCY));
        end

        // Random traffic, rates and shifts against the model.
        for (int t = 0; t < 4; t++) begin
            rate  = RATE_WIDTH'($urandom_range(2, 8));
            shift = SHIFT_WIDTH'($urandom_range(0, 24));
            applyStimulus(1'b0, 0, 1'b1);
            for (int i = 0; i < 150; i++) begin
                if (i % 25 == 0) begin
                    shift = (t == 3) ? SHIFT_WIDTH'($urandom_range(0, 127))
                                     : SHIFT_WIDTH'($urandom_range(0, 30));
                end
                applyStimulus($urandom_range(0, 9) < 7, longint'($urandom_range(0, 65535)), 1'b0);
            end
            idle(LATENCY + 2);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
